// File: rtl/matrix_op_defs_pkg.sv
// Shared types for the matrix op dispatcher and its attached op units.
// Holds the status codes, opcode encoding, dispatcher states and bus widths.
package matrix_op_defs_pkg;

    localparam int MATRIX_ADDR_WIDTH = 10;
    localparam int MATRIX_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        MATRIX_OP_STATUS_SUCCESS     = 3'd0,
        MATRIX_OP_STATUS_ERR_DIM     = 3'd1,
        MATRIX_OP_STATUS_ERR_ID      = 3'd2,
        MATRIX_OP_STATUS_ERR_OP      = 3'd3,
        MATRIX_OP_STATUS_ERR_TIMEOUT = 3'd4
    } matrix_op_status_e;

    typedef enum logic [1:0] {
        MATRIX_OPCODE_ADD       = 2'd0,
        MATRIX_OPCODE_MUL       = 2'd1,
        MATRIX_OPCODE_SCALAR    = 2'd2,
        MATRIX_OPCODE_TRANSPOSE = 2'd3
    } matrix_opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_RESP
    } dispatch_state_e;

endpackage

// File: rtl/matrix_op_port_mux.sv
// Routes the shared BRAM read port and shared matrix writer to the selected op unit.
// Everything is driven to zero when no operation is active or for unselected units.
module matrix_op_port_mux
    import matrix_op_defs_pkg::*;
#(
    parameter int N_OPS = 4
) (
    input  logic                         i_active,
    input  logic [1:0]                   i_sel,
    input  logic [MATRIX_ADDR_WIDTH-1:0] i_opReadAddr [N_OPS],
    input  logic [N_OPS-1:0]             i_opWriteRequest,
    input  logic [2:0]                   i_opMatrixId [N_OPS],
    input  logic [7:0]                   i_opActualRows [N_OPS],
    input  logic [7:0]                   i_opActualCols [N_OPS],
    input  logic [7:0][7:0]              i_opMatrixName [N_OPS],
    input  logic [MATRIX_DATA_WIDTH-1:0] i_opDataIn [N_OPS],
    input  logic [N_OPS-1:0]             i_opDataValid,
    output logic [N_OPS-1:0]             o_opWriteReady,
    output logic [N_OPS-1:0]             o_opWriterReady,
    output logic [N_OPS-1:0]             o_opWriteDone,
    output logic [MATRIX_ADDR_WIDTH-1:0] o_memReadAddr,
    output logic                         o_writeRequest,
    output logic [2:0]                   o_matrixId,
    output logic [7:0]                   o_actualRows,
    output logic [7:0]                   o_actualCols,
    output logic [7:0][7:0]              o_matrixName,
    output logic [MATRIX_DATA_WIDTH-1:0] o_dataIn,
    output logic                         o_dataValid,
    input  logic                         i_writeReady,
    input  logic                         i_writerReady,
    input  logic                         i_writeDone
);

    // Comparing against each index avoids reading past N_OPS for an out-of-range selector.
    always_comb begin
        o_memReadAddr   = '0;
        o_writeRequest  = 1'b0;
        o_matrixId      = '0;
        o_actualRows    = '0;
        o_actualCols    = '0;
        o_matrixName    = '0;
        o_dataIn        = '0;
        o_dataValid     = 1'b0;
        o_opWriteReady  = '0;
        o_opWriterReady = '0;
        o_opWriteDone   = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (i_active && (i_sel == 2'(i))) begin
                o_memReadAddr      = i_opReadAddr[i];
                o_writeRequest     = i_opWriteRequest[i];
                o_matrixId         = i_opMatrixId[i];
                o_actualRows       = i_opActualRows[i];
                o_actualCols       = i_opActualCols[i];
                o_matrixName       = i_opMatrixName[i];
                o_dataIn           = i_opDataIn[i];
                o_dataValid        = i_opDataValid[i];
                o_opWriteReady[i]  = i_writeReady;
                o_opWriterReady[i] = i_writerReady;
                o_opWriteDone[i]   = i_writeDone;
            end
        end
    end

endmodule

// File: rtl/matrix_op_dispatch.sv
// Accepts one matrix command at a time, launches the matching op unit, lends it the
// shared read/write ports while it runs, and returns its status (or a watchdog timeout).
module matrix_op_dispatch
    import matrix_op_defs_pkg::*;
#(
    parameter int N_OPS          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [2:0]                   cmd_a_id,
    input  logic [2:0]                   cmd_b_id,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output matrix_op_status_e            rsp_status,
    output logic [1:0]                   rsp_op,
    output logic [N_OPS-1:0]             op_start,
    output logic [2:0]                   op_a_id,
    output logic [2:0]                   op_b_id,
    input  logic [N_OPS-1:0]             op_busy,
    input  matrix_op_status_e            op_status [N_OPS],
    input  logic [MATRIX_ADDR_WIDTH-1:0] op_read_addr [N_OPS],
    output logic [MATRIX_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [N_OPS-1:0]             op_write_request,
    input  logic [2:0]                   op_matrix_id [N_OPS],
    input  logic [7:0]                   op_actual_rows [N_OPS],
    input  logic [7:0]                   op_actual_cols [N_OPS],
    input  logic [7:0][7:0]              op_matrix_name [N_OPS],
    input  logic [MATRIX_DATA_WIDTH-1:0] op_data_in [N_OPS],
    input  logic [N_OPS-1:0]             op_data_valid,
    output logic [N_OPS-1:0]             op_write_ready,
    output logic [N_OPS-1:0]             op_writer_ready,
    output logic [N_OPS-1:0]             op_write_done,
    output logic                         write_request,
    output logic [2:0]                   matrix_id,
    output logic [7:0]                   actual_rows,
    output logic [7:0]                   actual_cols,
    output logic [7:0][7:0]              matrix_name,
    output logic [MATRIX_DATA_WIDTH-1:0] data_in,
    output logic                         data_valid,
    input  logic                         write_ready,
    input  logic                         writer_ready,
    input  logic                         write_done
);

    dispatch_state_e   r_state;
    dispatch_state_e   w_nextState;
    logic [1:0]        r_op;
    logic [2:0]        r_aId;
    logic [2:0]        r_bId;
    matrix_op_status_e r_rspStatus;
    logic [15:0]       r_wdCount;
    logic [15:0]       w_wdNext;
    logic              w_expired;
    logic              w_opValid;
    logic              w_selBusy;
    matrix_op_status_e w_selStatus;
    logic              w_active;

    assign w_opValid  = (int'(cmd_op) < N_OPS);
    assign w_wdNext   = r_wdCount + 16'd1;
    assign w_expired  = (w_wdNext >= 16'(TIMEOUT_CYCLES));
    assign w_active   = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_BUSY) || (r_state == ST_RUN);
    assign rsp_status = r_rspStatus;
    assign rsp_op     = r_op;
    assign op_a_id    = r_aId;
    assign op_b_id    = r_bId;

    always_comb begin
        w_selBusy   = 1'b0;
        w_selStatus = MATRIX_OP_STATUS_SUCCESS;
        for (int i = 0; i < N_OPS; i++) begin
            if (r_op == 2'(i)) begin
                w_selBusy   = op_busy[i];
                w_selStatus = op_status[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Completion is tested before expiry so a unit finishing on the last cycle keeps its status.
    always_comb begin
        w_nextState = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        op_start    = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_nextState = w_opValid ? ST_LAUNCH : ST_RESP;
            end
            ST_LAUNCH: begin
                for (int i = 0; i < N_OPS; i++) op_start[i] = (r_op == 2'(i));
                w_nextState = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (w_selBusy)      w_nextState = ST_RUN;
                else if (w_expired) w_nextState = ST_RESP;
            end
            ST_RUN: begin
                if (!w_selBusy || w_expired) w_nextState = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_aId       <= '0;
            r_bId       <= '0;
            r_rspStatus <= MATRIX_OP_STATUS_SUCCESS;
            r_wdCount   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_aId <= cmd_a_id;
                        r_bId <= cmd_b_id;
                        if (!w_opValid) r_rspStatus <= MATRIX_OP_STATUS_ERR_OP;
                    end
                end
                ST_LAUNCH: r_wdCount <= '0;
                ST_WAIT_BUSY: begin
                    r_wdCount <= w_wdNext;
                    if (!w_selBusy && w_expired) r_rspStatus <= MATRIX_OP_STATUS_ERR_TIMEOUT;
                end
                ST_RUN: begin
                    r_wdCount <= w_wdNext;
                    if (!w_selBusy)     r_rspStatus <= w_selStatus;
                    else if (w_expired) r_rspStatus <= MATRIX_OP_STATUS_ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    matrix_op_port_mux #(.N_OPS(N_OPS)) u_portMux (
        .i_active        (w_active),
        .i_sel           (r_op),
        .i_opReadAddr    (op_read_addr),
        .i_opWriteRequest(op_write_request),
        .i_opMatrixId    (op_matrix_id),
        .i_opActualRows  (op_actual_rows),
        .i_opActualCols  (op_actual_cols),
        .i_opMatrixName  (op_matrix_name),
        .i_opDataIn      (op_data_in),
        .i_opDataValid   (op_data_valid),
        .o_opWriteReady  (op_write_ready),
        .o_opWriterReady (op_writer_ready),
        .o_opWriteDone   (op_write_done),
        .o_memReadAddr   (mem_read_addr),
        .o_writeRequest  (write_request),
        .o_matrixId      (matrix_id),
        .o_actualRows    (actual_rows),
        .o_actualCols    (actual_cols),
        .o_matrixName    (matrix_name),
        .o_dataIn        (data_in),
        .o_dataValid     (data_valid),
        .i_writeReady    (write_ready),
        .i_writerReady   (writer_ready),
        .i_writeDone     (write_done)
    );

endmodule

// File: tb/tb_matrix_op_dispatch.sv
// Self-checking bench for matrix_op_dispatch with three stub op units and a stub shared writer.
// Responses are queued by a monitor and compared in order against an expected-response queue.
module tb_matrix_op_dispatch;
    import matrix_op_defs_pkg::*;

    localparam int NU      = 3;
    localparam int TIMEOUT = 20;

    typedef struct {
        matrix_op_status_e status;
        logic [1:0]        op;
    } rsp_t;

    typedef struct {
        logic [1:0]        op;
        logic [2:0]        a;
        logic [2:0]        b;
        int                busyLen;
        matrix_op_status_e unitStatus;
        bit                neverBusy;
        matrix_op_status_e expStatus;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0] cmd_op, rsp_op;
    logic [2:0] cmd_a_id, cmd_b_id, op_a_id, op_b_id;
    matrix_op_status_e rsp_status;
    logic [NU-1:0] op_start, op_busy, op_write_request, op_data_valid;
    logic [NU-1:0] op_write_ready, op_writer_ready, op_write_done;
    matrix_op_status_e op_status [NU];
    logic [MATRIX_ADDR_WIDTH-1:0] op_read_addr [NU];
    logic [MATRIX_ADDR_WIDTH-1:0] mem_read_addr;
    logic [2:0] op_matrix_id [NU];
    logic [7:0] op_actual_rows [NU];
    logic [7:0] op_actual_cols [NU];
    logic [7:0][7:0] op_matrix_name [NU];
    logic [MATRIX_DATA_WIDTH-1:0] op_data_in [NU];
    logic write_request, data_valid;
    logic [2:0] matrix_id;
    logic [7:0] actual_rows, actual_cols;
    logic [7:0][7:0] matrix_name;
    logic [MATRIX_DATA_WIDTH-1:0] data_in;
    logic write_ready, writer_ready, write_done;

    int                stubLen [NU];
    matrix_op_status_e stubStatus [NU];
    bit                stubNeverBusy [NU];
    int                uCnt [NU];
    logic              u1Valid;
    logic [15:0]       u1Data;
    int                u1Sent;

    rsp_t expQ [$];
    rsp_t rspQ [$];
    logic [MATRIX_DATA_WIDTH-1:0] memQ [$];
    int   rdIdx = 0;
    int   nChecks = 0;
    int   nFail = 0;
    bit   monWriter = 1'b0;
    int   wrongReady = 0;
    int   addr0Seen = 0;
    int   addr1Seen = 0;
    int   ready1Seen = 0;

    always #5 clk = ~clk;

    matrix_op_dispatch #(.N_OPS(NU), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a_id(cmd_a_id), .cmd_b_id(cmd_b_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_op(rsp_op),
        .op_start(op_start), .op_a_id(op_a_id), .op_b_id(op_b_id),
        .op_busy(op_busy), .op_status(op_status),
        .op_read_addr(op_read_addr), .mem_read_addr(mem_read_addr),
        .op_write_request(op_write_request), .op_matrix_id(op_matrix_id),
        .op_actual_rows(op_actual_rows), .op_actual_cols(op_actual_cols),
        .op_matrix_name(op_matrix_name), .op_data_in(op_data_in), .op_data_valid(op_data_valid),
        .op_write_ready(op_write_ready), .op_writer_ready(op_writer_ready), .op_write_done(op_write_done),
        .write_request(write_request), .matrix_id(matrix_id), .actual_rows(actual_rows),
        .actual_cols(actual_cols), .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
        .write_ready(write_ready), .writer_ready(writer_ready), .write_done(write_done)
    );

    // Units 0 and 2 hold their writer-master lines high so any misrouting shows up downstream.
    assign op_read_addr[0]  = 10'h3FF;
    assign op_read_addr[1]  = 10'h055;
    assign op_read_addr[2]  = 10'h2AA;
    assign op_data_in[0]    = 16'hDEAD;
    assign op_data_in[1]    = u1Data;
    assign op_data_in[2]    = 16'hBEEF;
    assign op_write_request = {1'b1, op_busy[1], 1'b1};
    assign op_data_valid    = {1'b1, u1Valid, 1'b1};
    assign write_ready      = 1'b1;
    assign writer_ready     = 1'b1;
    assign write_done       = 1'b0;

    for (genvar g = 0; g < NU; g++) begin : g_unit
        assign op_status[g]      = stubStatus[g];
        assign op_matrix_id[g]   = 3'(g + 1);
        assign op_actual_rows[g] = 8'(g + 2);
        assign op_actual_cols[g] = 8'(g + 3);
        assign op_matrix_name[g] = {8{8'(65 + g)}};
    end

    // Stub op units: busy for stubLen cycles after start; unit 1 streams four words to the writer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_busy <= '0;
            u1Valid <= 1'b0;
            u1Data  <= '0;
            u1Sent  <= 0;
            for (int i = 0; i < NU; i++) uCnt[i] <= 0;
        end else begin
            for (int i = 0; i < NU; i++) begin
                if (op_start[i] && !stubNeverBusy[i]) begin
                    uCnt[i]    <= stubLen[i];
                    op_busy[i] <= 1'b1;
                end else if (uCnt[i] > 0) begin
                    uCnt[i] <= uCnt[i] - 1;
                    if (uCnt[i] == 1) op_busy[i] <= 1'b0;
                end
            end
            u1Valid <= 1'b0;
            if (op_start[1]) u1Sent <= 0;
            else if (op_busy[1] && op_writer_ready[1] && u1Sent < 4) begin
                u1Valid <= 1'b1;
                u1Data  <= 16'hA0 + 16'(u1Sent);
                u1Sent  <= u1Sent + 1;
            end
        end
    end

    always @(posedge clk) if (rst_n && data_valid) memQ.push_back(data_in);

    always @(negedge clk) if (rst_n && rsp_valid && rsp_ready) rspQ.push_back('{rsp_status, rsp_op});

    always @(negedge clk) begin
        if (monWriter) begin
            if (op_writer_ready[0] | op_writer_ready[2] | op_write_ready[0] | op_write_ready[2]) wrongReady++;
            if (mem_read_addr == 10'h3FF) addr0Seen++;
            if (mem_read_addr == 10'h055) addr1Seen++;
            if (op_writer_ready[1]) ready1Seen++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expPush(input matrix_op_status_e s, input logic [1:0] op);
        expQ.push_back('{s, op});
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        int c = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a_id = a; cmd_b_id = b;
        do begin @(negedge clk); c++; end while (!cmd_ready && c < 100);
        if (!cmd_ready) begin
            nChecks++; nFail++;
            $display("[TB] FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles", c);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input string name);
        int c = 0;
        while (rspQ.size() <= rdIdx && c < 200) begin @(negedge clk); #1; c++; end
        if (rspQ.size() <= rdIdx) begin
            nChecks++; nFail++;
            $display("[TB] FAIL %s: no response within %0d cycles", name, c);
        end else begin
            checkOutput({name, "_status"}, rspQ[rdIdx].status, expQ[rdIdx].status);
            checkOutput({name, "_op"}, rspQ[rdIdx].op, expQ[rdIdx].op);
            rdIdx++;
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   c;
        int   memBase;
        int   rspBefore;

        vecs[0] = '{2'd0, 3'd1, 3'd2, 10, MATRIX_OP_STATUS_SUCCESS, 1'b0, MATRIX_OP_STATUS_SUCCESS};
        vecs[1] = '{2'd2, 3'd3, 3'd4, 3,  MATRIX_OP_STATUS_ERR_ID,  1'b0, MATRIX_OP_STATUS_ERR_ID};
        vecs[2] = '{2'd0, 3'd5, 3'd6, 5,  MATRIX_OP_STATUS_ERR_DIM, 1'b0, MATRIX_OP_STATUS_ERR_DIM};
        vecs[3] = '{2'd3, 3'd7, 3'd1, 1,  MATRIX_OP_STATUS_SUCCESS, 1'b0, MATRIX_OP_STATUS_ERR_OP};
        vecs[4] = '{2'd1, 3'd2, 3'd3, 1,  MATRIX_OP_STATUS_SUCCESS, 1'b0, MATRIX_OP_STATUS_SUCCESS};
        vecs[5] = '{2'd2, 3'd6, 3'd5, 1,  MATRIX_OP_STATUS_SUCCESS, 1'b1, MATRIX_OP_STATUS_ERR_TIMEOUT};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a_id = '0; cmd_b_id = '0; rsp_ready = 1'b1;
        for (int i = 0; i < NU; i++) begin
            stubLen[i] = 5; stubStatus[i] = MATRIX_OP_STATUS_SUCCESS; stubNeverBusy[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_status", rsp_status, MATRIX_OP_STATUS_SUCCESS);
        checkOutput("reset_op_start", op_start, 3'b000);
        checkOutput("reset_op_ids", {op_a_id, op_b_id}, 6'd0);
        checkOutput("reset_mem_addr", mem_read_addr, 10'h000);
        checkOutput("reset_writer_ready", op_writer_ready, 3'b000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_cmd_ready", cmd_ready, 1'b1);

        // Launch pulse timing and operand broadcast for an ADD command.
        stubLen[0] = 10;
        expPush(MATRIX_OP_STATUS_SUCCESS, 2'd0);
        applyStimulus(2'd0, 3'd1, 3'd2);
        @(negedge clk);
        checkOutput("launch_op_start", op_start, 3'b001);
        checkOutput("launch_ids", {op_a_id, op_b_id}, {3'd1, 3'd2});
        checkOutput("launch_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        checkOutput("launch_pulse_width", op_start, 3'b000);
        waitRsp("add_rsp");

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].op < 2'd3) begin
                stubLen[vecs[v].op]       = vecs[v].busyLen;
                stubStatus[vecs[v].op]    = vecs[v].unitStatus;
                stubNeverBusy[vecs[v].op] = vecs[v].neverBusy;
            end
            expPush(vecs[v].expStatus, vecs[v].op);
            applyStimulus(vecs[v].op, vecs[v].a, vecs[v].b);
            checkOutput($sformatf("vec%0d_a_id", v), op_a_id, vecs[v].a);
            waitRsp($sformatf("vec%0d", v));
        end
        stubNeverBusy[2] = 1'b0;

        // Unit 1 streams four words through the shared writer.
        memBase = memQ.size();
        stubLen[1] = 10; stubStatus[1] = MATRIX_OP_STATUS_SUCCESS;
        monWriter = 1'b1;
        expPush(MATRIX_OP_STATUS_SUCCESS, 2'd1);
        applyStimulus(2'd1, 3'd2, 3'd3);
        waitRsp("writer_rsp");
        monWriter = 1'b0;
        checkOutput("writer_word_count", memQ.size() - memBase, 4);
        for (int k = 0; k < 4; k++)
            if (memBase + k < memQ.size())
                checkOutput($sformatf("writer_word%0d", k), memQ[memBase + k], 16'hA0 + 16'(k));
        checkOutput("writer_other_ready", wrongReady, 0);
        checkOutput("writer_unit0_addr", addr0Seen, 0);
        checkOutput("writer_unit1_addr_seen", addr1Seen > 0, 1'b1);
        checkOutput("writer_ready1_seen", ready1Seen > 0, 1'b1);
        @(negedge clk);
        checkOutput("writer_ready1_released", op_writer_ready, 3'b000);

        // Response held under backpressure; a pending command waits for rsp_ready.
        rsp_ready = 1'b0;
        stubLen[0] = 2; stubStatus[0] = MATRIX_OP_STATUS_ERR_DIM;
        expPush(MATRIX_OP_STATUS_ERR_DIM, 2'd0);
        applyStimulus(2'd0, 3'd4, 3'd5);
        c = 0;
        do begin @(negedge clk); c++; end while (!rsp_valid && c < 100);
        checkOutput("bp_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        stubLen[2] = 2; stubStatus[2] = MATRIX_OP_STATUS_SUCCESS;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a_id = 3'd6; cmd_b_id = 3'd7;
        expPush(MATRIX_OP_STATUS_SUCCESS, 2'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold_valid%0d", k), rsp_valid, 1'b1);
            checkOutput($sformatf("bp_hold_cmd_ready%0d", k), cmd_ready, 1'b0);
            checkOutput($sformatf("bp_hold_status%0d", k), rsp_status, MATRIX_OP_STATUS_ERR_DIM);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        waitRsp("bp_first");
        c = 0;
        do begin @(negedge clk); c++; end while (!cmd_ready && c < 100);
        checkOutput("bp_second_accepted", cmd_ready, 1'b1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        waitRsp("bp_second");

        // Watchdog expiry when the unit never reports busy.
        stubNeverBusy[2] = 1'b1;
        expPush(MATRIX_OP_STATUS_ERR_TIMEOUT, 2'd2);
        applyStimulus(2'd2, 3'd1, 3'd1);
        @(negedge clk);
        checkOutput("to_launch_pulse", op_start, 3'b100);
        c = 0;
        do begin
            @(negedge clk); c++;
            if (c == 5) begin
                checkOutput("to_mirror_addr", mem_read_addr, 10'h2AA);
                checkOutput("to_mirror_wreq", write_request, 1'b1);
            end
        end while (!rsp_valid && c < 100);
        checkOutput("to_latency", c, TIMEOUT + 1);
        checkOutput("to_released_addr", mem_read_addr, 10'h000);
        checkOutput("to_released_wreq", write_request, 1'b0);
        checkOutput("to_released_dvalid", data_valid, 1'b0);
        waitRsp("to_rsp");
        stubNeverBusy[2] = 1'b0;

        // Opcode beyond N_OPS responds on the next cycle without launching anything.
        expPush(MATRIX_OP_STATUS_ERR_OP, 2'd3);
        applyStimulus(2'd3, 3'd2, 3'd2);
        @(negedge clk);
        checkOutput("errop_rsp_valid", rsp_valid, 1'b1);
        checkOutput("errop_no_start", op_start, 3'b000);
        checkOutput("errop_status", rsp_status, MATRIX_OP_STATUS_ERR_OP);
        waitRsp("errop_rsp");

        // Reset during RUN aborts the command silently.
        stubLen[0] = 10; stubStatus[0] = MATRIX_OP_STATUS_SUCCESS;
        applyStimulus(2'd0, 3'd5, 3'd6);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_run_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_run_op_start", op_start, 3'b000);
        checkOutput("rst_run_ids", {op_a_id, op_b_id}, 6'd0);
        checkOutput("rst_run_mem_addr", mem_read_addr, 10'h000);
        checkOutput("rst_run_wreq", write_request, 1'b0);
        checkOutput("rst_run_status", rsp_status, MATRIX_OP_STATUS_SUCCESS);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rspBefore = rspQ.size();
        repeat (5) @(negedge clk);
        checkOutput("rst_run_no_rsp", rspQ.size(), rspBefore);
        checkOutput("rst_run_cmd_ready", cmd_ready, 1'b1);
        stubLen[1] = 3;
        expPush(MATRIX_OP_STATUS_SUCCESS, 2'd1);
        applyStimulus(2'd1, 3'd3, 3'd4);
        waitRsp("after_reset_rsp");

        repeat (3) @(negedge clk);
        checkOutput("rsp_count", rspQ.size(), expQ.size());

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
